// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared widths and fetch request states for the 16-bit CPU
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int INSTR_WIDTH        = 16;
  localparam int ADDR_WIDTH_DEFAULT = 8;

  // REQ_DROP: a read is outstanding whose data must be discarded (redirected)
  typedef enum logic [1:0] {
    REQ_IDLE = 2'd0,
    REQ_WAIT = 2'd1,
    REQ_DROP = 2'd2
  } req_state_e;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
// ============================================================================
// instruction_fetch_if : instruction-memory and decoder handshakes of fetch
// Revision: 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH_DEFAULT
);
  import cpu_pkg::*;

  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   instr_valid;
  logic                   decode_ready;

  modport master (
    output imem_req, imem_addr, instruction, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, decode_ready
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_pc, instr_valid,
    output imem_ack, imem_rdata, decode_ready
  );

endinterface : instruction_fetch_if

`default_nettype wire

// File: rtl/instr_queue.sv
// ============================================================================
// instr_queue : 2-entry {word, pc} prefetch FIFO, head always in entry 0
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_queue
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [INSTR_WIDTH-1:0] push_word_i,
  input  logic [ADDR_WIDTH-1:0]  push_pc_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [INSTR_WIDTH-1:0] head_word_o,
  output logic [ADDR_WIDTH-1:0]  head_pc_o,
  output logic                   valid_o,
  output logic [1:0]             count_next_o
);

  logic [INSTR_WIDTH-1:0] word0_q, word0_d, word1_q, word1_d;
  logic [ADDR_WIDTH-1:0]  pc0_q, pc0_d, pc1_q, pc1_d;
  logic [1:0]             count_q, count_d;
  logic                   do_pop;

  assign do_pop = pop_i && (count_q != 2'd0);

  always_comb begin
    word0_d = word0_q;
    word1_d = word1_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (do_pop) begin
        word0_d = word1_q;
        pc0_d   = pc1_q;
      end
      if (push_i) begin
        // New word lands in whichever slot becomes the tail after the pop
        if ((count_q == 2'd0) || ((count_q == 2'd1) && do_pop)) begin
          word0_d = push_word_i;
          pc0_d   = push_pc_i;
        end else begin
          word1_d = push_word_i;
          pc1_d   = push_pc_i;
        end
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word0_q <= '0;
      word1_q <= '0;
      pc0_q   <= '0;
      pc1_q   <= '0;
      count_q <= 2'd0;
    end else begin
      word0_q <= word0_d;
      word1_q <= word1_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      count_q <= count_d;
    end
  end

  assign head_word_o  = word0_q;
  assign head_pc_o    = pc0_q;
  assign valid_o      = (count_q != 2'd0);
  assign count_next_o = count_d;

endmodule : instr_queue

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch : PC, single-outstanding imem request FSM, redirect/drop
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                   ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_fetch_if.master   bus,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target
);

  req_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pending;
  logic                  ack_fire;
  logic                  push;
  logic                  pop;
  logic [1:0]            count_next;

  assign pending  = (state_q != REQ_IDLE);
  assign ack_fire = pending && bus.imem_ack;
  assign push     = ack_fire && (state_q == REQ_WAIT) && !branch_taken;
  assign pop      = bus.instr_valid && bus.decode_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;

    if (push) begin
      fetch_pc_d = addr_q + ADDR_WIDTH'(1);
    end
    if (branch_taken) begin
      fetch_pc_d = branch_target;
    end

    if (pending && !bus.imem_ack) begin
      // Address must stay stable until ack; a redirect only marks the data dead
      if (branch_taken) begin
        state_d = REQ_DROP;
      end
    end else if (count_next < 2'd2) begin
      state_d = REQ_WAIT;
      addr_d  = fetch_pc_d;
    end else begin
      state_d = REQ_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= REQ_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  assign bus.imem_req  = pending;
  assign bus.imem_addr = addr_q;

  instr_queue #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_word_i  (bus.imem_rdata),
    .push_pc_i    (addr_q),
    .pop_i        (pop),
    .flush_i      (branch_taken),
    .head_word_o  (bus.instruction),
    .head_pc_o    (bus.instr_pc),
    .valid_o      (bus.instr_valid),
    .count_next_o (count_next)
  );

endmodule : instruction_fetch

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// tb_instruction_fetch : directed + randomized check against a queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch;
  import cpu_pkg::*;

  localparam int AW   = 8;
  localparam int MASK = (1 << AW) - 1;
  localparam int RPC  = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          br;
  logic [AW-1:0] tgt;

  instruction_fetch_if #(.ADDR_WIDTH(AW)) bus ();
  instruction_fetch_if #(.ADDR_WIDTH(AW)) bus2 ();

  instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .branch_taken  (br),
    .branch_target (tgt)
  );

  // Second instance: wrap-around start address, zero-wait memory, always ready
  instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(8'hFE)) dut2 (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus2),
    .branch_taken  (1'b0),
    .branch_target (8'h00)
  );

  assign bus2.imem_ack     = bus2.imem_req;
  assign bus2.imem_rdata   = 16'hA000 + {8'h00, bus2.imem_addr};
  assign bus2.decode_ready = 1'b1;

  always #5 clk = ~clk;

  // Reference model state
  bit m_req, m_drop;
  int m_addr, m_pc;
  int q_word[$];
  int q_pc[$];

  int n_assert = 0;
  int n_fail   = 0;
  int lat_fixed, wcnt, cur_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req  = 1'b0;
    m_drop = 1'b0;
    m_addr = RPC;
    m_pc   = RPC;
    q_word.delete();
    q_pc.delete();
    wcnt   = 0;
  endtask

  task automatic drive_mem(input bit junk);
    if (bus.imem_req) begin
      if (wcnt == 0) cur_lat = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
      if (wcnt >= cur_lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hA000 + 16'(bus.imem_addr);
        wcnt = 0;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'($urandom);
        wcnt++;
      end
    end else begin
      bus.imem_ack   = junk ? 1'($urandom) : 1'b0;
      bus.imem_rdata = 16'($urandom);
      wcnt = 0;
    end
  endtask

  // Spec rules applied to the current inputs to get the state after the edge
  task automatic model_step();
    bit ack_fire, pop;
    ack_fire = m_req && bus.imem_ack;
    pop      = (q_pc.size() > 0) && bus.decode_ready;
    if (pop) begin
      void'(q_word.pop_front());
      void'(q_pc.pop_front());
    end
    if (ack_fire && !m_drop && !br) begin
      q_word.push_back(int'(bus.imem_rdata));
      q_pc.push_back(m_addr);
      m_pc = (m_addr + 1) & MASK;
    end
    if (br) begin
      q_word.delete();
      q_pc.delete();
      m_pc = int'(tgt);
    end
    if (m_req && !bus.imem_ack) begin
      if (br) m_drop = 1'b1;
    end else begin
      m_drop = 1'b0;
      m_req  = (q_pc.size() < 2);
      if (m_req) m_addr = m_pc;
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(bus.imem_req), 32'(m_req));
    chk("imem_addr", 32'(bus.imem_addr), m_addr);
    chk("instr_valid", 32'(bus.instr_valid), 32'(q_pc.size() > 0));
    if (q_pc.size() > 0) begin
      chk("instruction", 32'(bus.instruction), q_word[0]);
      chk("instr_pc", 32'(bus.instr_pc), q_pc[0]);
    end
  endtask

  task automatic cycle(input bit junk);
    drive_mem(junk);
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b1;
    br    = 1'b0;
    tgt   = '0;
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = '0;
    bus.decode_ready = 1'b0;
    lat_fixed = 0;
    cur_lat   = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instruction", 32'(bus.instruction), 32'd0);
    chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
    chk("rst2_addr", 32'(bus2.imem_addr), 32'hFE);

    // First-word latency and back-to-back streaming
    reset = 1'b0;
    bus.decode_ready = 1'b1;
    cycle(0);
    chk("e0_req", 32'(bus.imem_req), 32'd1);
    chk("e0_valid", 32'(bus.instr_valid), 32'd0);
    cycle(0);
    chk("e1_valid", 32'(bus.instr_valid), 32'd1);
    chk("e1_pc", 32'(bus.instr_pc), 32'h00);
    chk("e1_word", 32'(bus.instruction), 32'hA000);
    chk("wrap_pc0", 32'(bus2.instr_pc), 32'hFE);
    cycle(0);
    chk("e2_word", 32'(bus.instruction), 32'hA001);
    chk("wrap_pc1", 32'(bus2.instr_pc), 32'hFF);
    cycle(0);
    chk("e3_word", 32'(bus.instruction), 32'hA002);
    chk("wrap_pc2", 32'(bus2.instr_pc), 32'h00);
    cycle(0);
    chk("wrap_pc3", 32'(bus2.instr_pc), 32'h01);

    // Decoder stall: queue fills to two and requests stop
    bus.decode_ready = 1'b0;
    repeat (6) cycle(0);
    chk("stall_req_low", 32'(bus.imem_req), 32'd0);
    chk("stall_head", 32'(bus.instr_pc), 32'h03);
    bus.decode_ready = 1'b1;
    cycle(0);
    chk("drain_head", 32'(bus.instr_pc), 32'h04);
    chk("drain_reissue", 32'(bus.imem_addr), 32'h05);
    cycle(0);
    chk("drain_next", 32'(bus.instr_pc), 32'h05);

    // Redirect on the same edge as ack and pop
    br = 1'b1; tgt = 8'h20;
    cycle(0);
    br = 1'b0;
    chk("flush_valid", 32'(bus.instr_valid), 32'd0);
    chk("flush_req", 32'(bus.imem_req), 32'd1);
    chk("flush_addr", 32'(bus.imem_addr), 32'h20);
    cycle(0);
    chk("tgt20_pc", 32'(bus.instr_pc), 32'h20);
    chk("tgt20_word", 32'(bus.instruction), 32'hA020);

    // Redirect while a slow read of 0x05 is outstanding
    lat_fixed = 3;
    br = 1'b1; tgt = 8'h05;
    cycle(0);
    br = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req && (bus.imem_addr == 8'h05) && (wcnt == 0)) begin
        found = 1'b1;
        break;
      end
      cycle(0);
    end
    chk("find_req05", 32'(found), 32'd1);
    br = 1'b1; tgt = 8'h40;
    cycle(0);
    br = 1'b0;
    chk("drop_hold_req", 32'(bus.imem_req), 32'd1);
    chk("drop_hold_addr", 32'(bus.imem_addr), 32'h05);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle(0);
      if (bus.instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("tgt40_seen", 32'(found), 32'd1);
    chk("tgt40_pc", 32'(bus.instr_pc), 32'h40);
    chk("tgt40_word", 32'(bus.instruction), 32'hA040);

    // Reset in the middle of a wait
    bus.decode_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle(0);
      if (bus.instr_valid && bus.imem_req && (wcnt != 0)) begin
        found = 1'b1;
        break;
      end
    end
    chk("midwait_found", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_req", 32'(bus.imem_req), 32'd0);
    chk("async_valid", 32'(bus.instr_valid), 32'd0);
    bus.imem_ack = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.decode_ready = 1'b1;
    lat_fixed = 0;
    cycle(0);
    chk("restart_req", 32'(bus.imem_req), 32'd1);
    chk("restart_addr", 32'(bus.imem_addr), RPC);
    cycle(0);
    chk("restart_pc", 32'(bus.instr_pc), RPC);
    chk("restart_word", 32'(bus.instruction), 32'hA000);

    // Randomized traffic: variable latency, stalls, redirects, stray acks
    lat_fixed = -1;
    for (int i = 0; i < 4000; i++) begin
      bus.decode_ready = ($urandom % 4) != 0;
      br  = ($urandom % 16) == 0;
      tgt = AW'($urandom);
      cycle(1);
    end
    br = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_instruction_fetch

`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end fetch stage of the 16-bit CPU. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned instruction words in a 2-entry prefetch queue. The queue presents one instruction plus its PC to the combinational instruction decoder under a valid/ready handshake. Branch redirects from execute flush the queue and restart fetch at the target, discarding any in-flight read.

## Interface
Parameters:
- ADDR_WIDTH, 8: instruction word-address width; PC wraps modulo 2^ADDR_WIDTH.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_req  out  1  read request; held high until acked.
- imem_addr  out  ADDR_WIDTH  word address; stable while imem_req high and unacked.
- imem_ack  in  1  memory completes the read in this cycle; sampled only when imem_req high.
- imem_rdata  in  16  instruction word; valid in the imem_ack cycle.
- instruction  out  16  head-of-queue word to the decoder.
- instr_pc  out  ADDR_WIDTH  address of the head word.
- instr_valid  out  1  head entry present.
- decode_ready  in  1  decoder consumes the head when instr_valid & decode_ready.
- branch_taken  in  1  one-cycle redirect pulse.
- branch_target  in  ADDR_WIDTH  new fetch address, valid with branch_taken.

## Operation
- State: fetch_pc, imem_req/imem_addr registers, drop flag, queue (2 entries of {word, pc}, count 0..2).
- Reset values: imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, drop=0, count=0, instr_valid=0, instruction=0, instr_pc=0.
- Issue: at most one read outstanding. When imem_req is low and the slot rule allows, the block drives imem_req=1 and imem_addr=fetch_pc.
- Slot rule: imem_req next = 1 if a request is pending and not acked this edge. Otherwise imem_req next = (count_next < 2).
- Completion: on an edge with imem_req & imem_ack & !drop, push {imem_rdata, imem_addr} and set fetch_pc = imem_addr+1, wrapping. If the next request is issued back-to-back, imem_addr next = imem_addr+1.
- Pop: on an edge with instr_valid & decode_ready, advance the head and decrement count. Push and pop on the same edge leave count unchanged.
- Redirect: on an edge with branch_taken:
  - flush the queue (count=0) and set fetch_pc=branch_target;
  - a same-edge pop is still a completed handshake, but the flush wins;
  - a same-edge ack has its data discarded;
  - if a request is outstanding and unacked, set drop=1 and keep imem_req/imem_addr unchanged (protocol stability).
- Drop: on the acking edge with drop=1, discard the data, clear drop, and issue the next request at fetch_pc (the branch target). A second redirect while drop=1 only updates fetch_pc.
- Wrap: the address after 2^ADDR_WIDTH-1 is 0. There is no fault.

## Timing
- Outputs are registered; there is no combinational path from any input to any output.
- Reset released before edge E0: imem_req=1 after E0. With a zero-wait memory (ack in the same cycle), instr_valid=1 after E1, so first-word latency is 2 cycles.
- Steady state with a zero-wait memory and decode_ready=1: one instruction per cycle.
- Queue full (count=2, no pop): imem_req falls after the current ack and the block issues nothing until a pop.
- Redirect with a zero-wait memory: the target word is valid 2 cycles after the branch_taken edge. Each wait cycle of an outstanding dropped read adds its latency.
- Reset mid-transfer: all state clears asynchronously, imem_req drops immediately, and any pending ack is ignored.

## Structure
- Shared package cpu_pkg: INSTR_WIDTH=16 and the default address width constant. The decoder uses the same constant for its instruction port.
- Sub-module instr_queue: a 2-entry {word, pc} FIFO with push, pop, synchronous flush and count outputs. instruction_fetch holds the PC, request FSM and drop logic.

## Test plan
- Reset, zero-wait memory returning word = 16'hA000 + addr, decode_ready=1: instr_valid rises 2 cycles after reset release; the decoder sees A000@0, A001@1, A002@2 on consecutive cycles.
- decode_ready=0 for 6 cycles: exactly 2 words are queued, imem_req goes low, and no third request is issued. Raising decode_ready drains in order with no loss or duplication.
- 3-cycle memory latency, branch_taken with target 8'h40 while a read of 8'h05 is outstanding: imem_addr holds 8'h05 until ack, that data never appears, and the next request is 8'h40 with instr_pc=8'h40.
- branch_taken on the same edge as ack and as a pop: the queue is empty the next cycle, the acked word is discarded, and the next request is the target.
- RESET_PC=8'hFE, zero-wait memory: instr_pc sequence FE, FF, 00, 01.
- reset asserted while imem_req is high mid-wait: imem_req=0 and instr_valid=0 immediately. After release, fetch restarts at RESET_PC.
